apb_irq_ctrl: RTL and testbench
===============================

# apb_irq_ctrl

APB-mapped interrupt controller that consumes the `irq_o` vector of the timer subsystem (overflow and compare lines, two per timer). It also accepts any other level-high event sources. Each input has rising-edge detection, a sticky pending bit, and a mask bit. The controller presents one priority-encoded interrupt request with an ID to the core and clears the pending bit on the core's acknowledge.

## Interface
- `APB_ADDR_WIDTH`, 12, APB address width (4 KB slave).
- `IRQ_CNT`, 4, number of interrupt inputs; legal range 2..32. Default matches two timers × two lines.
- `HCLK` in 1, single clock for all logic.
- `HRESETn` in 1, asynchronous active-low reset.
- `PADDR` in APB_ADDR_WIDTH, APB address.
- `PWDATA` in 32, APB write data.
- `PWRITE` in 1, APB write strobe.
- `PSEL` in 1, APB select.
- `PENABLE` in 1, APB enable.
- `PRDATA` out 32, APB read data.
- `PREADY` out 1, APB ready; always 1.
- `PSLVERR` out 1, APB error.
- `irq_i` in IRQ_CNT, level interrupt sources; connects directly to the timer `irq_o` bus.
- `irq_o` out 1, interrupt request to the core.
- `irq_id_o` out $clog2(IRQ_CNT), index of the winning interrupt.
- `irq_ack_i` in 1, single-cycle acknowledge from the core for the ID currently on `irq_id_o`.

## Operation
- **Register map** (word offset = `PADDR[3:2]`, bits above IRQ_CNT read as 0):
  - 0x0 MASK, RW: 1 enables the line.
  - 0x4 PENDING, RW: read returns the pending bits; writing 1 to a bit clears it; writing 0 has no effect.
  - 0x8 SET, WO: writing 1 to a bit sets it pending. Reads return 0.
  - 0xC ID, RO: bit 31 = `irq_o`, bits [4:0] = `irq_id_o`, all other bits 0. Writes are ignored and raise no error.
- **Address decode:**
  - `PADDR[APB_ADDR_WIDTH-1:4]` nonzero → `PSLVERR`=1 during the access phase.
  - That access reads 0 and has no write side effect.
- **Access phase:** `PSEL & PENABLE`. Writes commit on the `HCLK` edge that ends the access phase.
- **Edge detection:**
  - `irq_q` is the previous-cycle copy of `irq_i`.
  - `edge = irq_i & ~irq_q`. An edge sets the pending bit regardless of MASK.
  - Level-high inputs do not re-trigger after being cleared.
- **Request and ID:**
  - `active = PENDING & MASK`.
  - `irq_o = |active`.
  - `irq_id_o` = lowest set index of `active` (index 0 has highest priority); 0 when `active`=0.
- **Acknowledge:** `irq_ack_i` with `irq_o`=1 clears `PENDING[irq_id_o]`. `irq_ack_i` with `irq_o`=0 is ignored.
- **Per-bit pending next-state, by priority:**
  - Set (edge or SET write) wins over clear (PENDING write-1 or ack) in the same cycle.
  - Otherwise clear.
  - Otherwise hold.
- Masking a pending line removes it from arbitration but keeps it pending. Unmasking re-asserts `irq_o` with no new edge.

## Timing
- **Reset values:**
  - Registers: MASK=0, PENDING=0, `irq_q`=0.
  - Outputs: `irq_o`=0, `irq_id_o`=0, `PRDATA`=0, `PREADY`=1, `PSLVERR`=0.
- **Reset mid-operation:** all state clears immediately (asynchronously); APB transfers in flight are lost.
- **Input high at reset release:** an input already high when reset releases counts as an edge, because `irq_q`=0. It pends on the first clock.
- **Edge latency:** `irq_i` rises before edge N; PENDING sets at edge N; `irq_o` and `irq_id_o` are valid after edge N. These outputs are combinational from registers only.
- **Ack latency:** ack sampled at edge N → the next winner is presented after edge N. The core must not ack twice for one ID.
- **APB:**
  - `PRDATA` is combinational during the access phase and 0 otherwise. Zero wait states.
  - A read of PENDING in the same cycle as a set or clear returns the pre-edge value.

## Structure
- **Package `apb_irq_ctrl_pkg`:**
  - Register offset constants `IRQ_MASK`=2'd0, `IRQ_PENDING`=2'd1, `IRQ_SET`=2'd2, `IRQ_ID`=2'd3.
  - ID field position `IRQ_ID_VALID_BIT`=31.
- **Sub-module `irq_prio_enc`:**
  - Parameter N.
  - Ports: `req_i[N]`, `valid_o`, `id_o[$clog2(N)]`.
  - Lowest-index-first. Reusable by other event units.

## Test plan
- **Reset and single edge:** after reset, MASK=0xF; drive `irq_i`=4'b0100 → next cycle `irq_o`=1, `irq_id_o`=2, ID reads 0x8000_0002; holding `irq_i` high after ack → no re-pend.
- **Priority:**
  - Pend bits 3 and 1, both masked in → `irq_id_o`=1.
  - Ack → `irq_id_o`=3 one cycle later.
  - Ack → `irq_o`=0, PENDING=0.
- **Mask gating:**
  - MASK=0; edge on bit 0 → PENDING=0x1, `irq_o`=0.
  - Write MASK=0x1 → `irq_o`=1 the cycle after the write edge, no new `irq_i` edge.
- **Software access:**
  - SET write 0xA → PENDING=0xA.
  - PENDING write 0x2 → PENDING=0x8.
  - A write to ID leaves state unchanged with `PSLVERR`=0.
  - Access at 0x010 → `PSLVERR`=1, `PRDATA`=0, no state change.
- **Collisions:**
  - Edge on bit 2 in the same cycle as a PENDING write-1 to bit 2 → bit 2 stays pending.
  - Ack of ID 2 coinciding with a new edge on bit 2 → stays pending.
- **Async reset mid-operation:** assert `HRESETn`=0 with PENDING=0xF between clock edges → PENDING=0 and `irq_o`=0 immediately; an input held high through reset release → pends on the first clock.

Source files
------------

// File: rtl/apb_irq_ctrl_pkg.sv
// Shared register offsets and field positions for the APB interrupt controller.
// Imported by the controller top and its testbench.
package apb_irq_ctrl_pkg;

   localparam logic [1:0] IRQ_MASK    = 2'd0;
   localparam logic [1:0] IRQ_PENDING = 2'd1;
   localparam logic [1:0] IRQ_SET     = 2'd2;
   localparam logic [1:0] IRQ_ID      = 2'd3;

   localparam int IRQ_ID_VALID_BIT = 31;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder; index 0 has the highest priority.
// id_o is 0 when no request is present.
module irq_prio_enc #(
   parameter int N   = 4,
   parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]   req_i,
   output logic           valid_o,
   output logic [IDW-1:0] id_o
);

   always_comb begin
      valid_o = |req_i;
      id_o    = '0;
      // Scan downward so the lowest set index is the last to be assigned.
      for (int i = N - 1; i >= 0; i--) begin
         if (req_i[i]) id_o = IDW'(i);
      end
   end

endmodule

// File: rtl/apb_irq_ctrl.sv
// APB interrupt controller: rising-edge capture into sticky pending bits,
// per-line mask, priority-encoded request/ID and acknowledge-driven clear.
module apb_irq_ctrl
   import apb_irq_ctrl_pkg::*;
#(
   parameter int APB_ADDR_WIDTH = 12,
   parameter int IRQ_CNT        = 4
) (
   input  logic                       HCLK,
   input  logic                       HRESETn,
   input  logic [APB_ADDR_WIDTH-1:0]  PADDR,
   input  logic [31:0]                PWDATA,
   input  logic                       PWRITE,
   input  logic                       PSEL,
   input  logic                       PENABLE,
   output logic [31:0]                PRDATA,
   output logic                       PREADY,
   output logic                       PSLVERR,
   input  logic [IRQ_CNT-1:0]         irq_i,
   output logic                       irq_o,
   output logic [$clog2(IRQ_CNT)-1:0] irq_id_o,
   input  logic                       irq_ack_i
);

   localparam int IDW = $clog2(IRQ_CNT);

   logic [IRQ_CNT-1:0] mask_reg,    mask_next;
   logic [IRQ_CNT-1:0] pending_reg, pending_next;
   logic [IRQ_CNT-1:0] irq_q_reg;

   logic               access;
   logic               addr_err;
   logic               wr_en;
   logic [1:0]         offset;
   logic [IRQ_CNT-1:0] wdata;
   logic [IRQ_CNT-1:0] active;
   logic [IRQ_CNT-1:0] edge_vec;
   logic [IRQ_CNT-1:0] set_vec;
   logic [IRQ_CNT-1:0] clr_vec;
   logic [31:0]        id_word;
   logic               unused_bits;

   assign access      = PSEL & PENABLE;
   assign addr_err    = |PADDR[APB_ADDR_WIDTH-1:4];
   assign wr_en       = access & PWRITE & ~addr_err;
   assign offset      = PADDR[3:2];
   assign wdata       = PWDATA[IRQ_CNT-1:0];
   assign unused_bits = ^{PADDR[1:0], PWDATA};

   assign PREADY  = 1'b1;
   assign PSLVERR = access & addr_err;

   assign active   = pending_reg & mask_reg;
   assign edge_vec = irq_i & ~irq_q_reg;

   irq_prio_enc #(
      .N   (IRQ_CNT),
      .IDW (IDW)
   ) u_prio_enc (
      .req_i   (active),
      .valid_o (irq_o),
      .id_o    (irq_id_o)
   );

   // Sets take precedence over clears so a coincident edge is never lost.
   always_comb begin
      set_vec = edge_vec;
      clr_vec = '0;
      if (wr_en && offset == IRQ_SET)     set_vec = set_vec | wdata;
      if (wr_en && offset == IRQ_PENDING) clr_vec = wdata;
      if (irq_ack_i && irq_o)             clr_vec = clr_vec | (IRQ_CNT'(1) << irq_id_o);
      pending_next = set_vec | (pending_reg & ~clr_vec);
      mask_next    = (wr_en && offset == IRQ_MASK) ? wdata : mask_reg;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         mask_reg    <= '0;
         pending_reg <= '0;
         irq_q_reg   <= '0;
      end else begin
         mask_reg    <= mask_next;
         pending_reg <= pending_next;
         irq_q_reg   <= irq_i;
      end
   end

   always_comb begin
      id_word                   = '0;
      id_word[IRQ_ID_VALID_BIT] = irq_o;
      id_word[IDW-1:0]          = irq_id_o;
   end

   always_comb begin
      PRDATA = '0;
      if (access && !addr_err) begin
         case (offset)
            IRQ_MASK:    PRDATA[IRQ_CNT-1:0] = mask_reg;
            IRQ_PENDING: PRDATA[IRQ_CNT-1:0] = pending_reg;
            IRQ_ID:      PRDATA = id_word;
            default:     PRDATA = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_irq_ctrl.sv
// Directed testbench for apb_irq_ctrl with hand-computed expectations.
// Inputs change on the falling clock edge; outputs are sampled away from the rising edge.
module tb_apb_irq_ctrl;
   import apb_irq_ctrl_pkg::*;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic [11:0] PADDR;
   logic [31:0] PWDATA;
   logic        PWRITE;
   logic        PSEL;
   logic        PENABLE;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;
   logic [3:0]  irq_i;
   logic        irq_o;
   logic [1:0]  irq_id_o;
   logic        irq_ack_i;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] rd;
   logic        err;

   apb_irq_ctrl #(
      .APB_ADDR_WIDTH (12),
      .IRQ_CNT        (4)
   ) dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .PADDR     (PADDR),
      .PWDATA    (PWDATA),
      .PWRITE    (PWRITE),
      .PSEL      (PSEL),
      .PENABLE   (PENABLE),
      .PRDATA    (PRDATA),
      .PREADY    (PREADY),
      .PSLVERR   (PSLVERR),
      .irq_i     (irq_i),
      .irq_o     (irq_o),
      .irq_id_o  (irq_id_o),
      .irq_ack_i (irq_ack_i)
   );

   always #5 HCLK = ~HCLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // irq_acc is applied to irq_i at the start of the access phase, so an edge
   // can be made to coincide with the committing clock edge.
   task automatic apb_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] irq_acc);
      @(negedge HCLK);
      PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
      @(negedge HCLK);
      PENABLE = 1'b1; irq_i = irq_acc;
      #1 err = PSLVERR;
      @(negedge HCLK);
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      $display("APB WR addr=0x%03h data=0x%08h slverr=%0b", a, d, err);
   endtask

   task automatic apb_read(input logic [11:0] a);
      @(negedge HCLK);
      PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
      @(negedge HCLK);
      PENABLE = 1'b1;
      #1 begin rd = PRDATA; err = PSLVERR; end
      @(negedge HCLK);
      PSEL = 1'b0; PENABLE = 1'b0;
      $display("APB RD addr=0x%03h data=0x%08h slverr=%0b", a, rd, err);
   endtask

   task automatic ack_once();
      @(negedge HCLK);
      irq_ack_i = 1'b1;
      @(negedge HCLK);
      irq_ack_i = 1'b0;
      $display("ACK irq_o=%0b id=%0d", irq_o, irq_id_o);
   endtask

   initial begin
      HRESETn = 1'b0; PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PSEL = 1'b0;
      PENABLE = 1'b0; irq_i = '0; irq_ack_i = 1'b0;
      #12;
      check("rst_irq_o",   32'(irq_o),    32'h0);
      check("rst_irq_id",  32'(irq_id_o), 32'h0);
      check("rst_pready",  32'(PREADY),   32'h1);
      check("rst_pslverr", 32'(PSLVERR),  32'h0);
      check("rst_prdata",  PRDATA,        32'h0);
      @(negedge HCLK); HRESETn = 1'b1;
      apb_read(12'h000); check("rst_mask",    rd, 32'h0);
      apb_read(12'h004); check("rst_pending", rd, 32'h0);

      // Single edge with all lines enabled
      apb_write(12'h000, 32'hF, 4'b0000);
      @(negedge HCLK); irq_i = 4'b0100;
      @(negedge HCLK);
      check("edge_irq_o",  32'(irq_o),    32'h1);
      check("edge_irq_id", 32'(irq_id_o), 32'h2);
      apb_read(12'h00C); check("edge_id_reg", rd, 32'h8000_0002);
      ack_once();
      check("ack_irq_o", 32'(irq_o), 32'h0);
      repeat (2) @(negedge HCLK);
      apb_read(12'h004); check("level_no_repend", rd, 32'h0);
      irq_i = 4'b0000;

      // Priority between lines 1 and 3
      @(negedge HCLK); irq_i = 4'b1010;
      @(negedge HCLK);
      check("prio_id_first", 32'(irq_id_o), 32'h1);
      ack_once();
      check("prio_irq_o_second", 32'(irq_o),    32'h1);
      check("prio_id_second",    32'(irq_id_o), 32'h3);
      ack_once();
      check("prio_irq_o_done", 32'(irq_o), 32'h0);
      apb_read(12'h004); check("prio_pending_done", rd, 32'h0);
      irq_i = 4'b0000;

      // Mask gating: pend while masked, then unmask without a new edge
      apb_write(12'h000, 32'h0, 4'b0000);
      @(negedge HCLK); irq_i = 4'b0001;
      @(negedge HCLK);
      check("mask_irq_o_off", 32'(irq_o), 32'h0);
      apb_read(12'h004); check("mask_pending", rd, 32'h1);
      apb_write(12'h000, 32'h1, 4'b0001);
      check("unmask_irq_o", 32'(irq_o),    32'h1);
      check("unmask_id",    32'(irq_id_o), 32'h0);
      ack_once();
      check("unmask_ack_irq_o", 32'(irq_o), 32'h0);
      irq_i = 4'b0000;

      // Software SET / PENDING clear / ID write / bad address
      apb_write(12'h000, 32'h0, 4'b0000);
      apb_write(12'h008, 32'hA, 4'b0000);
      apb_read(12'h004); check("sw_set_pending", rd, 32'hA);
      apb_read(12'h008); check("sw_set_reads0",  rd, 32'h0);
      apb_write(12'h004, 32'h2, 4'b0000);
      apb_read(12'h004); check("sw_clr_pending", rd, 32'h8);
      apb_write(12'h00C, 32'hFFFF_FFFF, 4'b0000);
      check("id_wr_slverr", 32'(err), 32'h0);
      apb_read(12'h004); check("id_wr_pending", rd, 32'h8);
      apb_read(12'h000); check("id_wr_mask",    rd, 32'h0);
      apb_write(12'h010, 32'hF, 4'b0000);
      check("bad_wr_slverr", 32'(err), 32'h1);
      apb_read(12'h010);
      check("bad_rd_slverr", 32'(err), 32'h1);
      check("bad_rd_prdata", rd,       32'h0);
      apb_read(12'h000); check("bad_wr_mask", rd, 32'h0);
      apb_write(12'h004, 32'hF, 4'b0000);
      apb_read(12'h004); check("sw_clear_all", rd, 32'h0);

      // Collision: edge on bit 2 with PENDING write-1 to bit 2
      apb_write(12'h004, 32'h4, 4'b0100);
      apb_read(12'h004); check("coll_wr_pending", rd, 32'h4);
      irq_i = 4'b0000;
      apb_write(12'h000, 32'h4, 4'b0000);
      check("coll_irq_id", 32'(irq_id_o), 32'h2);
      // Collision: ack of ID 2 with a new edge on bit 2
      @(negedge HCLK); irq_ack_i = 1'b1; irq_i = 4'b0100;
      @(negedge HCLK); irq_ack_i = 1'b0;
      check("coll_ack_irq_o", 32'(irq_o), 32'h1);
      apb_read(12'h004); check("coll_ack_pending", rd, 32'h4);
      ack_once();
      check("coll_final_irq_o", 32'(irq_o), 32'h0);

      // Async reset mid-operation with an input held high
      apb_write(12'h008, 32'hF, 4'b0001);
      apb_write(12'h000, 32'hF, 4'b0001);
      check("pre_rst_irq_o", 32'(irq_o), 32'h1);
      @(posedge HCLK); #2 HRESETn = 1'b0;
      #1;
      check("async_rst_irq_o",   32'(irq_o),          32'h0);
      check("async_rst_pending", 32'(dut.pending_reg), 32'h0);
      $display("RESET asserted mid-cycle irq_o=%0b", irq_o);
      @(negedge HCLK); HRESETn = 1'b1;
      @(negedge HCLK);
      check("post_rst_irq_o", 32'(irq_o), 32'h0);
      apb_read(12'h004); check("post_rst_pending", rd, 32'h1);
      apb_write(12'h000, 32'h1, 4'b0001);
      check("post_rst_unmask", 32'(irq_o), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
